// File: rtl/hazard_fwd_unit_if.sv
// ID-stage hazard/forwarding bundle between the ID control decoder and hazard_fwd_unit.
// master: the decoder side, which drives the decoded instruction and flush and reads back stall/forwarding.
// slave: hazard_fwd_unit itself.
interface hazard_fwd_unit_if #(
    parameter int NREG_BITS = 5,
    parameter int FWD_DEPTH = 3
);
    localparam int SW = $clog2(FWD_DEPTH + 1);

    logic                 id_valid;
    logic [NREG_BITS-1:0] id_rs;
    logic [NREG_BITS-1:0] id_rt;
    logic                 id_use_rs;
    logic                 id_use_rt;
    logic                 id_wreg;
    logic [NREG_BITS-1:0] id_rn;
    logic                 id_m2reg;
    logic                 flush;
    logic                 stall;
    logic                 issue;
    logic [SW-1:0]        fwda_stage;
    logic [SW-1:0]        fwdb_stage;
    logic                 fwda_ld;
    logic                 fwdb_ld;
    logic [31:0]          stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn, id_m2reg, flush,
        input  stall, issue, fwda_stage, fwdb_stage, fwda_ld, fwdb_ld, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn, id_m2reg, flush,
        output stall, issue, fwda_stage, fwdb_stage, fwda_ld, fwdb_ld, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: ID-stage data-hazard unit.
// Keeps a shadow pipeline of in-flight destination registers (stage 1 = EXE ... stage FWD_DEPTH),
// picks the youngest matching producer for each source operand, and stalls ID when that producer
// is a load whose data is not yet available (stage index <= LOAD_LAT).
// Optional feature: define HAZ_STALL_CNT_EN to build a saturating 32-bit stall-cycle counter;
// without it stall_cnt is tied to zero.
module hazard_fwd_unit #(
    parameter int NREG_BITS = 5,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1
) (
    input logic               clk,
    input logic               rst,
    hazard_fwd_unit_if.slave  bus
);
    localparam int SW = $clog2(FWD_DEPTH + 1);

    logic [FWD_DEPTH:1]   v;
    logic [FWD_DEPTH:1]   ld;
    logic [NREG_BITS-1:0] rn [1:FWD_DEPTH];

    logic          haz_a;
    logic          haz_b;
    logic [SW-1:0] stage_a;
    logic [SW-1:0] stage_b;
    logic          ld_a;
    logic          ld_b;
    logic          stall_i;
    logic          issue_i;
    logic          load_s1;

    // Operand resolution: scan oldest to youngest so the youngest match overwrites any older one,
    // which also hides older matches sitting behind a younger hazardous load.
    always_comb begin
        stage_a = '0;
        ld_a    = 1'b0;
        haz_a   = 1'b0;
        stage_b = '0;
        ld_b    = 1'b0;
        haz_b   = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (bus.id_use_rs && v[k] && (rn[k] == bus.id_rs) && (bus.id_rs != '0)) begin
                stage_a = SW'(k);
                ld_a    = ld[k] && (k > LOAD_LAT);
                haz_a   = ld[k] && (k <= LOAD_LAT);
            end
            if (bus.id_use_rt && v[k] && (rn[k] == bus.id_rt) && (bus.id_rt != '0)) begin
                stage_b = SW'(k);
                ld_b    = ld[k] && (k > LOAD_LAT);
                haz_b   = ld[k] && (k <= LOAD_LAT);
            end
        end
    end

    // Flush outranks stall; only a real, unstalled, unflushed instruction enters the shadow pipe.
    assign stall_i = bus.id_valid && !bus.flush && (haz_a || haz_b);
    assign issue_i = bus.id_valid && !stall_i && !bus.flush;
    assign load_s1 = issue_i && bus.id_wreg && (bus.id_rn != '0);

    assign bus.stall      = stall_i;
    assign bus.issue      = issue_i;
    assign bus.fwda_stage = stage_a;
    assign bus.fwdb_stage = stage_b;
    assign bus.fwda_ld    = ld_a;
    assign bus.fwdb_ld    = ld_b;

    // Shadow pipeline: stage 1 takes the issuing writer or a bubble, older stages shift every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v  <= '0;
            ld <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                rn[k] <= '0;
            end
        end else begin
            v[1]  <= load_s1;
            ld[1] <= load_s1 && bus.id_m2reg;
            rn[1] <= load_s1 ? bus.id_rn : '0;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                v[k]  <= v[k-1];
                ld[k] <= ld[k-1];
                rn[k] <= rn[k-1];
            end
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] cnt;

    // Stall-cycle counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall_i && (cnt != '1)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: one instance at FWD_DEPTH=3/LOAD_LAT=1 and one at
// FWD_DEPTH=4/LOAD_LAT=2, each driven through its own hazard_fwd_unit_if.
// stall_cnt expectations follow HAZ_STALL_CNT_EN (zero when the counter is not built).
module tb_hazard_fwd_unit;
    logic clk;
    logic rst;

    int pass_count;
    int fail_count;
    int total_count;

    hazard_fwd_unit_if #(.NREG_BITS(5), .FWD_DEPTH(3)) bus_a ();
    hazard_fwd_unit_if #(.NREG_BITS(5), .FWD_DEPTH(4)) bus_b ();

    hazard_fwd_unit #(.NREG_BITS(5), .FWD_DEPTH(3), .LOAD_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    hazard_fwd_unit #(.NREG_BITS(5), .FWD_DEPTH(4), .LOAD_LAT(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n);
`ifdef HAZ_STALL_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_count++;
        assert (obs === exp_v) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Waits for the falling edge, then drives one ID-stage instruction onto the selected unit
    // while the other unit sees an empty ID slot.
    task automatic applyStimulus(input int sel, input int valid, input int rs, input int rt,
                                 input int use_rs, input int use_rt, input int wreg,
                                 input int rn, input int m2reg, input int flush_i);
        @(negedge clk);
        if (sel == 0) begin
            bus_a.id_valid  = 1'(valid);
            bus_a.id_rs     = 5'(rs);
            bus_a.id_rt     = 5'(rt);
            bus_a.id_use_rs = 1'(use_rs);
            bus_a.id_use_rt = 1'(use_rt);
            bus_a.id_wreg   = 1'(wreg);
            bus_a.id_rn     = 5'(rn);
            bus_a.id_m2reg  = 1'(m2reg);
            bus_a.flush     = 1'(flush_i);
            bus_b.id_valid  = 1'b0;
            bus_b.id_use_rs = 1'b0;
            bus_b.id_use_rt = 1'b0;
            bus_b.id_wreg   = 1'b0;
            bus_b.flush     = 1'b0;
        end else begin
            bus_b.id_valid  = 1'(valid);
            bus_b.id_rs     = 5'(rs);
            bus_b.id_rt     = 5'(rt);
            bus_b.id_use_rs = 1'(use_rs);
            bus_b.id_use_rt = 1'(use_rt);
            bus_b.id_wreg   = 1'(wreg);
            bus_b.id_rn     = 5'(rn);
            bus_b.id_m2reg  = 1'(m2reg);
            bus_b.flush     = 1'(flush_i);
            bus_a.id_valid  = 1'b0;
            bus_a.id_use_rs = 1'b0;
            bus_a.id_use_rt = 1'b0;
            bus_a.id_wreg   = 1'b0;
            bus_a.flush     = 1'b0;
        end
    endtask

    // Samples the selected unit 1 time unit after the inputs change; e_sa < 0 marks the
    // forwarding outputs as don't-care for this step.
    task automatic checkOutput(input int sel, input string tag, input int e_stall, input int e_issue,
                               input int e_sa, input int e_la, input int e_sb, input int e_lb,
                               input int e_cnt);
        logic [31:0] o_stall, o_issue, o_sa, o_la, o_sb, o_lb, o_cnt;
        #1;
        if (sel == 0) begin
            o_stall = 32'(bus_a.stall);
            o_issue = 32'(bus_a.issue);
            o_sa    = 32'(bus_a.fwda_stage);
            o_la    = 32'(bus_a.fwda_ld);
            o_sb    = 32'(bus_a.fwdb_stage);
            o_lb    = 32'(bus_a.fwdb_ld);
            o_cnt   = bus_a.stall_cnt;
        end else begin
            o_stall = 32'(bus_b.stall);
            o_issue = 32'(bus_b.issue);
            o_sa    = 32'(bus_b.fwda_stage);
            o_la    = 32'(bus_b.fwda_ld);
            o_sb    = 32'(bus_b.fwdb_stage);
            o_lb    = 32'(bus_b.fwdb_ld);
            o_cnt   = bus_b.stall_cnt;
        end
        compare({tag, ".stall"}, o_stall, 32'(e_stall));
        compare({tag, ".issue"}, o_issue, 32'(e_issue));
        compare({tag, ".stall_cnt"}, o_cnt, 32'(e_cnt));
        if (e_sa >= 0) begin
            compare({tag, ".fwda_stage"}, o_sa, 32'(e_sa));
            compare({tag, ".fwda_ld"}, o_la, 32'(e_la));
            compare({tag, ".fwdb_stage"}, o_sb, 32'(e_sb));
            compare({tag, ".fwdb_ld"}, o_lb, 32'(e_lb));
        end
    endtask

    // Directed sequence: unit A (depth 3, latency 1) first, then unit B (depth 4, latency 2).
    initial begin
        pass_count  = 0;
        fail_count  = 0;
        total_count = 0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        checkOutput(0, "a_reset", 0, 0, 0, 0, 0, 0, 0);
        checkOutput(1, "b_reset", 0, 0, 0, 0, 0, 0, 0);

        // sel valid rs rt urs urt wreg rn m2reg flush
        applyStimulus(0, 1, 1, 2, 1, 1, 1, 3, 0, 0);     // add r3,r1,r2
        checkOutput(0, "a_add_r3", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 0, 1, 1, 1, 7, 0, 0);     // add r7,r3,r0
        checkOutput(0, "a_fwd_s1", 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 3, 1, 1, 1, 4, 1, 0);     // lw r4 reading r7,r3
        checkOutput(0, "a_fwd_s1_s2", 0, 1, 1, 0, 2, 0, 0);
        applyStimulus(0, 1, 4, 4, 1, 1, 1, 5, 0, 0);     // add r5,r4,r4 load-use
        checkOutput(0, "a_lduse_stall", 1, 0, -1, 0, 0, 0, exp_cnt(0));
        applyStimulus(0, 1, 4, 4, 1, 1, 1, 5, 0, 0);
        checkOutput(0, "a_lduse_fwd", 0, 1, 2, 1, 2, 1, exp_cnt(1));
        applyStimulus(0, 1, 0, 4, 1, 0, 1, 0, 0, 0);     // rs=r0, rt=r4 unused, writes r0
        checkOutput(0, "a_r0_nouse", 0, 1, 0, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
        checkOutput(0, "a_fwdb_s2", 0, 1, 0, 0, 2, 0, exp_cnt(1));
        applyStimulus(0, 1, 5, 1, 1, 1, 1, 6, 0, 0);     // add r6,r5,r1
        checkOutput(0, "a_fwd_s3", 0, 1, 3, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 6, 9, 1, 0, 1, 6, 0, 0);     // sub r6,r6
        checkOutput(0, "a_sub_r6", 0, 1, 1, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 6, 6, 1, 1, 0, 0, 0, 0);     // use r6 twice
        checkOutput(0, "a_youngest", 0, 1, 1, 0, 1, 0, exp_cnt(1));
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 0, 0);     // add r6
        checkOutput(0, "a_add_r6", 0, 1, 0, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 1, 0);     // lw r6
        checkOutput(0, "a_lw_r6", 0, 1, 0, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 6, 0, 1, 0, 0, 0, 0, 0);     // lw r6 at s1 over alu r6 at s2
        checkOutput(0, "a_ld_over_alu", 1, 0, -1, 0, 0, 0, exp_cnt(1));
        applyStimulus(0, 1, 6, 6, 1, 1, 1, 8, 0, 0);
        checkOutput(0, "a_ld_s2_over_s3", 0, 1, 2, 1, 2, 1, exp_cnt(2));
        applyStimulus(0, 1, 8, 0, 1, 0, 1, 10, 1, 0);    // lw r10 reading r8
        checkOutput(0, "a_lw_r10", 0, 1, 1, 0, 0, 0, exp_cnt(2));
        applyStimulus(0, 1, 10, 0, 1, 0, 1, 9, 0, 1);    // load-use on r10 with flush
        checkOutput(0, "a_flush", 0, 0, -1, 0, 0, 0, exp_cnt(2));
        applyStimulus(0, 1, 10, 9, 1, 1, 0, 0, 0, 0);    // flushed r9 must not forward
        checkOutput(0, "a_after_flush", 0, 1, 2, 1, 0, 0, exp_cnt(2));

        applyStimulus(1, 1, 0, 0, 0, 0, 1, 4, 1, 0);     // lw r4
        checkOutput(1, "b_lw_r4", 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 4, 4, 1, 1, 1, 5, 0, 0);     // add r5,r4,r4
        checkOutput(1, "b_stall_1", 1, 0, -1, 0, 0, 0, exp_cnt(0));
        applyStimulus(1, 1, 4, 4, 1, 1, 1, 5, 0, 0);
        checkOutput(1, "b_stall_2", 1, 0, -1, 0, 0, 0, exp_cnt(1));
        applyStimulus(1, 1, 4, 4, 1, 1, 1, 5, 0, 0);
        checkOutput(1, "b_fwd_s3_ld", 0, 1, 3, 1, 3, 1, exp_cnt(2));
        applyStimulus(1, 1, 4, 0, 1, 0, 1, 4, 1, 0);     // lw r4 reading r4 from stage 4
        checkOutput(1, "b_fwd_s4_ld", 0, 1, 4, 1, 0, 0, exp_cnt(2));
        applyStimulus(1, 1, 5, 0, 1, 0, 1, 11, 0, 0);    // independent add r11,r5
        checkOutput(1, "b_indep", 0, 1, 2, 0, 0, 0, exp_cnt(2));
        applyStimulus(1, 1, 4, 0, 1, 0, 0, 0, 0, 0);     // use r4, one instruction later
        checkOutput(1, "b_stall_gap", 1, 0, -1, 0, 0, 0, exp_cnt(2));
        applyStimulus(1, 1, 4, 0, 1, 0, 0, 0, 0, 0);
        checkOutput(1, "b_gap_fwd", 0, 1, 3, 1, 0, 0, exp_cnt(3));
        applyStimulus(1, 1, 11, 4, 0, 0, 0, 0, 0, 0);    // matches present but not read
        checkOutput(1, "b_nouse", 0, 1, 0, 0, 0, 0, exp_cnt(3));
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 12, 1, 0);    // lw r12
        checkOutput(1, "b_lw_r12", 0, 1, 0, 0, 0, 0, exp_cnt(3));
        applyStimulus(1, 1, 12, 0, 1, 0, 0, 0, 0, 0);
        checkOutput(1, "b_stall_r12", 1, 0, -1, 0, 0, 0, exp_cnt(3));
        applyStimulus(1, 1, 12, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        checkOutput(1, "b_rst_mid_stall", 1, 0, -1, 0, 0, 0, exp_cnt(4));
        applyStimulus(1, 1, 12, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        checkOutput(1, "b_after_rst", 0, 1, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised data-hazard unit for the pipelined CPU's ID stage: keeps its own shadow pipeline of in-flight destination registers, produces per-operand forwarding selects for any of FWD_DEPTH downstream stages, and stalls ID for load-use hazards whose data becomes available LOAD_LAT stages after EXE entry. It is the next generation of the fixed two-stage forwarding/stall logic in the ID control path: depth, load latency and register count are all configurable, and the block itself holds the stage state instead of taking it as ports. It sits beside the ID control decoder, which supplies decoded operand-use and write-back flags.

## Interface
- NREG_BITS, 5: register-specifier width; register 0 is hardwired zero.
- FWD_DEPTH, 3: number of downstream stages tracked (stage 1 = EXE … stage FWD_DEPTH = last stage before register-file write). Range 2..6.
- LOAD_LAT, 1: a load's data is forwardable only from stage index > LOAD_LAT. Constraint: 1 ≤ LOAD_LAT < FWD_DEPTH.
- Derived: SW = $clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  NREG_BITS  source specifiers.
- id_use_rs, id_use_rt  in  1  operand actually read.
- id_wreg  in  1  instruction writes a register.
- id_rn  in  NREG_BITS  destination specifier.
- id_m2reg  in  1  instruction is a load.
- flush  in  1  squash the ID instruction (taken branch/jump).
- stall  out  1  hold PC/IF/ID; bubble into EXE.
- issue  out  1  id_valid & ~stall & ~flush.
- fwda_stage, fwdb_stage  out  SW  0 = register file, k = stage k.
- fwda_ld, fwdb_ld  out  1  1 = take memory data at that stage, 0 = ALU result.
- stall_cnt  out  32  stall-cycle count (only with HAZ_STALL_CNT_EN).

## Operation
- Shadow entry per stage k: {v, rn, ld}. Stage 1 loads {1, id_rn, id_m2reg} when issue & id_wreg & id_rn≠0, else bubble {0,0,0}. Stage k+1 ← stage k every cycle (no back-pressure downstream). Stage FWD_DEPTH entry then retires.
- Operand match (rs shown, rt identical): match_k = id_use_rs & v_k & rn_k==id_rs & id_rs≠0. Priority: lowest k (youngest) wins.
- No match: fwda_stage=0, fwda_ld=0.
- Winning k, ld_k=0: fwda_stage=k, fwda_ld=0.
- Winning k, ld_k=1, k>LOAD_LAT: fwda_stage=k, fwda_ld=1.
- Winning k, ld_k=1, k≤LOAD_LAT: operand hazard.
- stall = id_valid & ~flush & (rs hazard | rt hazard). Older matches behind a younger hazardous match are ignored.
- flush has priority over stall: no bubble-for-stall, no issue, stage 1 gets bubble.
- When stall=1, fwd outputs are don't-care; the consumer ignores them.

## Timing
- stall, issue, fwd outputs: combinational from current inputs and registered shadow state, same cycle.
- Shadow shift: one register stage per cycle; load-use stall lasts exactly LOAD_LAT − k + 1 cycles for a load at stage k, max LOAD_LAT cycles.
- Reset (any cycle, including mid-stall): all v/rn/ld ← 0; next-cycle outputs stall=0, fwd*_stage=0, fwd*_ld=0; stall_cnt ← 0.
- Write in stage FWD_DEPTH retires the following cycle; register file must be write-before-read for that cycle.
- Simultaneous rs and rt matches to different stages resolved independently.

## Configuration
- HAZ_STALL_CNT_EN defined: 32-bit stall_cnt increments on every cycle with stall=1, saturates at 0xFFFF_FFFF, cleared by rst.
- Undefined: counter logic absent; stall_cnt ties to 0.

## Test plan
- FWD_DEPTH=3, LOAD_LAT=1: add r3 issued, next cycle ID reads rs=r3 -> fwda_stage=1, fwda_ld=0, stall=0.
- lw r4, then add r5,r4,r4 -> stall=1 for 1 cycle, stall_cnt=1; next cycle fwda_stage=fwdb_stage=2, fwda_ld=fwdb_ld=1.
- LOAD_LAT=2, FWD_DEPTH=4: lw r4, then use r4 -> stall 2 cycles, then stage 3 with ld=1; with one independent instruction between -> stall 1 cycle.
- Writes to r0, or id_use_rs=0 with rs matching -> stage 0, no stall, ever.
- add r6 then sub r6 then use r6 -> fwda_stage=1 (youngest), not 2; lw r6 at stage 1 over alu r6 at stage 2 -> stall.
- Assert flush during a load-use stall -> stall=0, issue=0, bubble; assert rst mid-stall -> next cycle all outputs 0, stall_cnt=0.
